// File: rtl/apb_master_bridge_if.sv
// APB4 bus bundle: the bridge drives it through the master modport,
// peripherals (or a bench model) use the slave modport.
`ifndef PADDR_SIZE
`define PADDR_SIZE 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

interface ApbIO #(
    parameter int ADDR_WIDTH = `PADDR_SIZE,
    parameter int DATA_WIDTH = `XLEN
);
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [2:0]              pprot;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic                    pready;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pslverr;

    modport master (
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding bridge from the core MMIO request/response channels to APB4,
// with a programmable ACCESS-phase timeout so a hung peripheral cannot stall the core.
`ifndef PADDR_SIZE
`define PADDR_SIZE 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module apb_master_bridge #(
    parameter int ADDR_WIDTH = `PADDR_SIZE,
    parameter int DATA_WIDTH = `XLEN,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_write,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    input  logic [2:0]              req_prot,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    ApbIO.master                    apb
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_WIDTH  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t                 state;
    logic [CNT_WIDTH-1:0]   wait_cnt;
    logic [ADDR_WIDTH-1:0]  paddr_q;
    logic [2:0]             pprot_q;
    logic                   psel_q;
    logic                   penable_q;
    logic                   pwrite_q;
    logic [DATA_WIDTH-1:0]  pwdata_q;
    logic [STRB_WIDTH-1:0]  pstrb_q;
    logic                   timeout_hit;

    // A zero TIMEOUT parameter disables the abort path entirely.
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            wait_cnt   <= '0;
            paddr_q    <= '0;
            pprot_q    <= '0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= '0;
            pstrb_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        paddr_q   <= req_addr;
                        pprot_q   <= req_prot;
                        pwrite_q  <= req_write;
                        pwdata_q  <= req_write ? req_wdata : '0;
                        pstrb_q   <= req_write ? req_wstrb : '0;
                        psel_q    <= 1'b1;
                        req_ready <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    wait_cnt  <= '0;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    // pready wins over a timeout that expires in the same cycle.
                    if (apb.pready) begin
                        resp_err   <= apb.pslverr;
                        resp_rdata <= (!pwrite_q && !apb.pslverr) ? apb.prdata : '0;
                        psel_q     <= 1'b0;
                        penable_q  <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else if (timeout_hit) begin
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                        psel_q     <= 1'b0;
                        penable_q  <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign apb.paddr   = paddr_q;
    assign apb.pprot   = pprot_q;
    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.pwdata  = pwdata_q;
    assign apb.pstrb   = pstrb_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed transfers against a scripted APB slave,
// with expected responses queued at issue and checked by an independent monitor.
module tb_apb_master_bridge;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [2:0]  req_prot;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    ApbIO #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb_bus ();

    apb_master_bridge #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .req_prot  (req_prot),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .apb       (apb_bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t       expQ[$];
    int          checks = 0;
    int          fails  = 0;
    int          slaveWait = 0;
    logic        slaveErr = 1'b0;
    logic [31:0] slaveRdata = 32'h0;
    int          accessCycles = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Scripted slave: pready after slaveWait wait states; -1 means never ready.
    initial begin
        apb_bus.pready  = 1'b0;
        apb_bus.prdata  = 32'h0;
        apb_bus.pslverr = 1'b0;
        forever begin
            @(negedge clk);
            if (apb_bus.psel && apb_bus.penable) begin
                apb_bus.pready = (slaveWait >= 0) && (accessCycles == slaveWait);
                apb_bus.prdata  = apb_bus.pready ? slaveRdata : 32'hCAFE_F00D;
                apb_bus.pslverr = apb_bus.pready ? slaveErr : 1'b1;
                accessCycles++;
            end else begin
                apb_bus.pready  = 1'b0;
                apb_bus.pslverr = 1'b0;
                accessCycles    = 0;
            end
        end
    end

    // Response monitor: scoreboard pop on handshake, stability check under backpressure.
    logic        heldValid = 1'b0;
    logic [31:0] heldRdata;
    logic        heldErr;
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (rst || !resp_valid) begin
                heldValid = 1'b0;
            end else begin
                if (heldValid) begin
                    checkOutput("hold_rdata", resp_rdata, heldRdata);
                    checkOutput("hold_err", resp_err, heldErr);
                end
                if (resp_ready) begin
                    heldValid = 1'b0;
                    if (expQ.size() == 0) begin
                        checks++;
                        fails++;
                        $display("[TB] FAIL unexpected_resp: got rdata %0h err %0b, expected no response", resp_rdata, resp_err);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("resp_rdata", resp_rdata, e.rdata);
                        checkOutput("resp_err", resp_err, e.err);
                    end
                end else begin
                    heldValid = 1'b1;
                    heldRdata = resp_rdata;
                    heldErr   = resp_err;
                end
            end
        end
    end

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_req_ready"}, req_ready, 1);
        checkOutput({tag, "_resp_valid"}, resp_valid, 0);
        checkOutput({tag, "_resp_rdata"}, resp_rdata, 0);
        checkOutput({tag, "_resp_err"}, resp_err, 0);
        checkOutput({tag, "_psel"}, apb_bus.psel, 0);
        checkOutput({tag, "_penable"}, apb_bus.penable, 0);
        checkOutput({tag, "_pwrite"}, apb_bus.pwrite, 0);
        checkOutput({tag, "_paddr"}, apb_bus.paddr, 0);
        checkOutput({tag, "_pwdata"}, apb_bus.pwdata, 0);
        checkOutput({tag, "_pstrb"}, apb_bus.pstrb, 0);
        checkOutput({tag, "_pprot"}, apb_bus.pprot, 0);
    endtask

    // Called at posedge+1 with the bridge idle; returns at posedge+1 after the response handshake.
    task automatic applyStimulus(
        input logic [31:0] addr, input logic wr, input logic [31:0] wdata, input logic [3:0] wstrb,
        input logic [2:0] prot, input int waits, input logic slvErr, input logic [31:0] rdata,
        input int expRespCycle, input logic [31:0] expRdata, input logic expErr, input int holdCycles);
        resp_t e;
        int    waited;
        int    cycle;
        e.rdata = expRdata;
        e.err   = expErr;
        expQ.push_back(e);
        slaveWait  = waits;
        slaveErr   = slvErr;
        slaveRdata = rdata;
        resp_ready = (holdCycles == 0);
        req_valid  = 1'b1;
        req_addr   = addr;
        req_write  = wr;
        req_wdata  = wdata;
        req_wstrb  = wstrb;
        req_prot   = prot;
        waited     = 0;
        @(negedge clk);
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("accept_wait", waited, 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'h5555_5555;
        req_write = ~wr;
        req_wdata = 32'hAAAA_AAAA;
        req_wstrb = 4'hF;
        req_prot  = 3'b000;
        cycle     = 1;
        forever begin
            @(negedge clk);
            if (resp_valid || cycle > 40) break;
            checkOutput("psel", apb_bus.psel, 1);
            checkOutput("penable", apb_bus.penable, (cycle > 1) ? 1 : 0);
            checkOutput("paddr", apb_bus.paddr, addr);
            checkOutput("pwrite", apb_bus.pwrite, wr);
            checkOutput("pwdata", apb_bus.pwdata, wr ? wdata : 32'h0);
            checkOutput("pstrb", apb_bus.pstrb, wr ? wstrb : 4'h0);
            checkOutput("pprot", apb_bus.pprot, prot);
            checkOutput("busy_req_ready", req_ready, 0);
            @(posedge clk);
            #1;
            cycle++;
        end
        checkOutput("resp_seen", resp_valid, 1);
        checkOutput("resp_cycle", cycle, expRespCycle);
        checkOutput("resp_psel", apb_bus.psel, 0);
        checkOutput("resp_penable", apb_bus.penable, 0);
        for (int h = 0; h < holdCycles; h++) begin
            checkOutput("bp_req_ready", req_ready, 0);
            checkOutput("bp_resp_valid", resp_valid, 1);
            @(posedge clk);
            #1;
            if (h == holdCycles - 1) resp_ready = 1'b1;
            @(negedge clk);
        end
        checkOutput("handshake_valid", resp_valid, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = 32'h0;
        req_write  = 1'b0;
        req_wdata  = 32'h0;
        req_wstrb  = 4'h0;
        req_prot   = 3'b000;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkResetState("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // zero-wait read
        applyStimulus(32'h1000_0004, 1'b0, 32'h0, 4'h0, 3'b001, 0, 1'b0, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 1'b0, 0);
        // write with 3 wait states
        applyStimulus(32'h1000_0010, 1'b1, 32'h1234_5678, 4'b0011, 3'b010, 3, 1'b0, 32'h7777_7777, 6, 32'h0, 1'b0, 0);
        // slave error on read
        applyStimulus(32'h2000_0000, 1'b0, 32'h0, 4'h0, 3'b100, 0, 1'b1, 32'hFFFF_FFFF, 3, 32'h0, 1'b1, 0);
        // timeout with pready never rising
        applyStimulus(32'h3000_0008, 1'b0, 32'h0, 4'h0, 3'b000, -1, 1'b0, 32'h1111_1111, 7, 32'h0, 1'b1, 0);
        // pready in the last ACCESS cycle beats the timeout
        applyStimulus(32'h3000_000C, 1'b0, 32'h0, 4'h0, 3'b011, 4, 1'b0, 32'hA5A5_0001, 7, 32'hA5A5_0001, 1'b0, 0);
        // response backpressure, then an immediate follow-up request
        applyStimulus(32'h4000_0000, 1'b0, 32'h0, 4'h0, 3'b101, 1, 1'b0, 32'h0BAD_CAFE, 4, 32'h0BAD_CAFE, 1'b0, 5);
        applyStimulus(32'h4000_0004, 1'b1, 32'hCAFE_BABE, 4'b1100, 3'b110, 0, 1'b0, 32'h0, 3, 32'h0, 1'b0, 0);

        // reset during an ACCESS wait state aborts without a response
        slaveWait  = -1;
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_addr   = 32'h5000_0020;
        req_write  = 1'b1;
        req_wdata  = 32'h8765_4321;
        req_wstrb  = 4'hF;
        req_prot   = 3'b111;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("pre_reset_penable", apb_bus.penable, 1);
        checkOutput("pre_reset_pwdata", apb_bus.pwdata, 32'h8765_4321);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkResetState("midreset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("post_reset_psel", apb_bus.psel, 0);
            checkOutput("post_reset_resp_valid", resp_valid, 0);
        end
        @(posedge clk);
        #1;
        applyStimulus(32'h1000_0040, 1'b0, 32'h0, 4'h0, 3'b000, 1, 1'b0, 32'h1357_9BDF, 4, 32'h1357_9BDF, 1'b0, 0);

        repeat (3) @(posedge clk);
        checkOutput("pending_responses", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Single-outstanding bridge between the core-side uncached/MMIO request port and the APB4 peripheral bus. Accepts one request on a valid/ready channel, runs the two-phase APB4 SETUP/ACCESS transfer on an `ApbIO.master` port, and returns read data plus an error flag on a valid/ready response channel. A programmable timeout terminates any access whose slave never asserts `pready`, so a hung peripheral cannot stall the core.

## Interface
Parameters:
- `ADDR_WIDTH`, default `` `PADDR_SIZE ``: APB address width.
- `DATA_WIDTH`, default `` `XLEN ``: APB data width; strobe width is `DATA_WIDTH/8`.
- `TIMEOUT`, default 255: maximum ACCESS-phase cycles with `pready`=0 before abort; 0 disables the timeout.

Ports:
- `clk`  in  1  the block's single clock.
- `rst`  in  1  synchronous reset, active-high.
- `req_valid`  in  1  upstream request valid.
- `req_ready`  out  1  bridge can accept a request.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_write`  in  1  1 = write, 0 = read.
- `req_wdata`  in  DATA_WIDTH  write data.
- `req_wstrb`  in  DATA_WIDTH/8  write byte strobes.
- `req_prot`  in  3  protection attributes, forwarded to `pprot`.
- `resp_valid`  out  1  response valid.
- `resp_ready`  in  1  upstream accepts response.
- `resp_rdata`  out  DATA_WIDTH  read data; 0 for writes and errors.
- `resp_err`  out  1  `pslverr` from slave, or timeout.
- `apb`  ApbIO.master  —  APB4 bus: `paddr`, `pprot`, `psel`, `penable`, `pwrite`, `pwdata`, `pstrb` out; `pready`, `prdata`, `pslverr` in.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: `req_ready`=1. On `req_valid & req_ready`, register addr/write/wdata/wstrb/prot and go to SETUP.
- SETUP: `psel`=1, `penable`=0, all APB outputs driven from the request registers; go to ACCESS unconditionally.
- ACCESS: `psel`=1, `penable`=1; APB outputs stay stable. When `pready`=1: capture `resp_err`=`pslverr`; capture `resp_rdata`=`prdata` if read and `pslverr`=0, otherwise 0; go to RESP.
- Timeout: counter of width `$clog2(TIMEOUT+1)` clears on entry to ACCESS and increments on every ACCESS cycle with `pready`=0. If `TIMEOUT`≠0 and the counter equals `TIMEOUT` while `pready`=0, set `resp_err`=1 and `resp_rdata`=0, then go to RESP. `pready`=1 in the same cycle overrides the timeout.
- RESP: `resp_valid`=1, `psel`=`penable`=0; hold the response until `resp_ready`, then go to IDLE.
- Reads drive `pstrb`=0 and `pwdata`=0. Writes drive `req_wstrb`/`req_wdata` unmodified.
- Only one transfer is outstanding at a time. `req_ready`=0 in SETUP, ACCESS and RESP.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `psel`=0, `penable`=0, `pwrite`=0, `paddr`=0, `pwdata`=0, `pstrb`=0, `pprot`=0, timeout counter 0.
- All outputs are registered or decoded from the registered state. There is no combinational path from `req_*` or `apb` inputs to outputs.
- Zero-wait-state slave: handshake in cycle 0, SETUP in cycle 1, ACCESS with `pready` in cycle 2, `resp_valid` in cycle 3. Each slave wait state adds 1 cycle.
- Earliest next accept is the cycle after the `resp_valid & resp_ready` handshake.
- Timeout abort: `resp_valid` rises `TIMEOUT`+1 cycles after ACCESS entry, and `psel` falls in the same cycle.
- Reset asserted mid-transfer, in any state: on the next edge all outputs take their reset values. The aborted transfer produces no response.
- Response fields stay stable while `resp_valid`=1 and `resp_ready`=0.

## Test plan
- Zero-wait read: addr 0x1000_0004 with slave `prdata`=0xDEADBEEF and `pready` tied high → `psel` in cycle 1, `penable` in cycle 2, `resp_valid` in cycle 3 with rdata 0xDEADBEEF and err 0; `pstrb`=0 throughout.
- Write with 3 wait states: wdata 0x12345678, wstrb 0b0011 → `pwrite`=1, `pstrb`=0b0011, `paddr`/`pwdata` stable across all 4 ACCESS cycles; `resp_valid` in cycle 6 with rdata 0 and err 0.
- Slave error: read with `pslverr`=1 and `pready`=1 → `resp_err`=1 and `resp_rdata`=0, even though `prdata`=0xFFFFFFFF.
- Timeout: `TIMEOUT`=4 with `pready` held at 0 → ACCESS lasts 5 cycles, `resp_valid` with err 1, and `psel`/`penable` drop. Repeat with `pready` rising in the last ACCESS cycle → normal completion with err 0.
- Response backpressure: `resp_ready` low for 5 cycles → `resp_valid`/data held stable and `req_ready`=0; a new request issued in the cycle after the handshake is accepted.
- Reset mid-ACCESS: assert `rst` for 1 cycle during a wait state → all outputs at reset values next cycle, no `resp_valid`; a subsequent read completes normally.
